// File: rtl/prt_pkg.sv
// Shared types and width helpers for the N-slot packet reference table.
package prt_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_VALID   = 2'd2
    } slot_state_e;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } r_state_e;

    function automatic int slot_w(input int num_slots);
        return $clog2(num_slots);
    endfunction

    function automatic int len_w(input int slot_depth);
        return $clog2(slot_depth + 1);
    endfunction

endpackage

// File: rtl/prt_slot_mem.sv
// Simple dual-port synchronous RAM holding every slot back to back.
module prt_slot_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/prt_nslot.sv
// N-slot packet reference table: one writer and one reader working on
// independent slots, with per-slot FREE/WRITING/VALID state and length.
//
// state  | meaning
// W_IDLE | no slot being written; a free slot may be claimed
// W_BUSY | appending words to wr_slot
// R_IDLE | no read in progress
// R_BUSY | streaming rd_slot, rd_ptr is the word on the output
module prt_nslot
    import prt_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int SLOT_DEPTH = 1024,
    parameter  int NUM_SLOTS  = 4,
    localparam int SW         = slot_w(NUM_SLOTS),
    localparam int LW         = len_w(SLOT_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN_start_writing_prt_entry,
    output logic [SW-1:0]         start_writing_prt_entry,
    output logic                  RDY_start_writing_prt_entry,
    input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
    input  logic                  EN_write_prt_entry,
    output logic                  RDY_write_prt_entry,
    input  logic                  EN_finish_writing_prt_entry,
    output logic                  RDY_finish_writing_prt_entry,
    input  logic                  EN_abort_writing_prt_entry,
    output logic                  RDY_abort_writing_prt_entry,
    input  logic [SW-1:0]         invalidate_prt_entry_slot,
    input  logic                  EN_invalidate_prt_entry,
    output logic                  RDY_invalidate_prt_entry,
    input  logic [SW-1:0]         start_reading_prt_entry_slot,
    input  logic                  EN_start_reading_prt_entry,
    output logic                  RDY_start_reading_prt_entry,
    input  logic                  EN_read_prt_entry,
    output logic [DATA_WIDTH:0]   read_prt_entry,
    output logic                  RDY_read_prt_entry,
    output logic                  is_prt_slot_free,
    output logic                  RDY_is_prt_slot_free,
    output logic [NUM_SLOTS-1:0]  prt_slot_valid
);

    localparam int            AW      = SW + LW - 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(SLOT_DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    slot_state_e     slot_state    [NUM_SLOTS];
    slot_state_e     slot_state_nx [NUM_SLOTS];
    logic [LW-1:0]   len           [NUM_SLOTS];
    logic [LW-1:0]   len_nx        [NUM_SLOTS];

    w_state_e        w_state, w_state_nx;
    logic [SW-1:0]   wr_slot, wr_slot_nx;
    logic [LW-1:0]   wr_len, wr_len_nx;
    r_state_e        r_state, r_state_nx;
    logic [SW-1:0]   rd_slot, rd_slot_nx;
    logic [LW-1:0]   rd_ptr, rd_ptr_nx;

    logic            any_free;
    logic [SW-1:0]   free_idx;
    logic            fire_start_w, fire_write, fire_finish, fire_abort;
    logic            fire_start_r, fire_read, inv_hit;
    logic [LW-1:0]   cur_len;
    logic            rd_last;
    logic [DATA_WIDTH-1:0] ram_q, rd_word;

    // Lowest-index free slot wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_state[i] == SLOT_FREE) begin
                any_free = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            prt_slot_valid[i] = (slot_state[i] == SLOT_VALID);
        end
    end

    assign start_writing_prt_entry      = free_idx;
    assign RDY_start_writing_prt_entry  = any_free && (w_state == W_IDLE);
    assign RDY_write_prt_entry          = (w_state == W_BUSY) && (wr_len < DEPTH_L);
    assign RDY_finish_writing_prt_entry = (w_state == W_BUSY);
    assign RDY_abort_writing_prt_entry  = (w_state == W_BUSY);
    assign RDY_invalidate_prt_entry     = 1'b1;
    assign RDY_start_reading_prt_entry  = (r_state == R_IDLE);
    assign RDY_read_prt_entry           = (r_state == R_BUSY);
    assign is_prt_slot_free             = any_free;
    assign RDY_is_prt_slot_free         = 1'b1;

    assign fire_start_w = EN_start_writing_prt_entry  && RDY_start_writing_prt_entry;
    assign fire_write   = EN_write_prt_entry          && RDY_write_prt_entry;
    assign fire_finish  = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
    assign fire_abort   = EN_abort_writing_prt_entry  && RDY_abort_writing_prt_entry;
    assign fire_start_r = EN_start_reading_prt_entry  && RDY_start_reading_prt_entry;
    assign fire_read    = EN_read_prt_entry           && RDY_read_prt_entry;
    assign inv_hit      = EN_invalidate_prt_entry &&
                          (slot_state[invalidate_prt_entry_slot] == SLOT_VALID);

    assign cur_len = len[rd_slot];
    assign rd_last = (cur_len == '0) || (rd_ptr == cur_len - ONE_L);
    assign rd_word = (cur_len == '0) ? '0 : ram_q;
    assign read_prt_entry = (r_state == R_BUSY) ? {rd_last, rd_word} : '0;

    always_comb begin
        slot_state_nx = slot_state;
        len_nx        = len;
        w_state_nx    = w_state;
        wr_slot_nx    = wr_slot;
        wr_len_nx     = wr_len;
        r_state_nx    = r_state;
        rd_slot_nx    = rd_slot;
        rd_ptr_nx     = rd_ptr;

        case (w_state)
            W_IDLE: begin
                if (fire_start_w) begin
                    slot_state_nx[free_idx] = SLOT_WRITING;
                    wr_slot_nx              = free_idx;
                    wr_len_nx               = '0;
                    w_state_nx              = W_BUSY;
                end
            end
            W_BUSY: begin
                if (fire_write) begin
                    wr_len_nx = wr_len + ONE_L;
                end
                if (fire_abort) begin
                    slot_state_nx[wr_slot] = SLOT_FREE;
                    w_state_nx             = W_IDLE;
                end else if (fire_finish) begin
                    slot_state_nx[wr_slot] = SLOT_VALID;
                    len_nx[wr_slot]        = wr_len_nx;
                    w_state_nx             = W_IDLE;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase

        // Only VALID slots are freed, so this never collides with the writer.
        if (inv_hit) begin
            slot_state_nx[invalidate_prt_entry_slot] = SLOT_FREE;
        end

        case (r_state)
            R_IDLE: begin
                if (fire_start_r &&
                    (slot_state[start_reading_prt_entry_slot] == SLOT_VALID) &&
                    !(inv_hit && (invalidate_prt_entry_slot == start_reading_prt_entry_slot))) begin
                    r_state_nx = R_BUSY;
                    rd_slot_nx = start_reading_prt_entry_slot;
                    rd_ptr_nx  = '0;
                end
            end
            R_BUSY: begin
                if (inv_hit && (invalidate_prt_entry_slot == rd_slot)) begin
                    r_state_nx = R_IDLE;
                end else if (fire_read) begin
                    if (rd_last) begin
                        r_state_nx = R_IDLE;
                    end else begin
                        rd_ptr_nx = rd_ptr + ONE_L;
                    end
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_state[i] <= SLOT_FREE;
                len[i]        <= '0;
            end
            w_state <= W_IDLE;
            wr_slot <= '0;
            wr_len  <= '0;
            r_state <= R_IDLE;
            rd_slot <= '0;
            rd_ptr  <= '0;
        end else begin
            slot_state <= slot_state_nx;
            len        <= len_nx;
            w_state    <= w_state_nx;
            wr_slot    <= wr_slot_nx;
            wr_len     <= wr_len_nx;
            r_state    <= r_state_nx;
            rd_slot    <= rd_slot_nx;
            rd_ptr     <= rd_ptr_nx;
        end
    end

    // Read address follows next-state pointer so the word is ready one cycle later.
    prt_slot_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (fire_write),
        .wr_addr ({wr_slot, wr_len[LW-2:0]}),
        .wr_data (write_prt_entry_data),
        .rd_addr ({rd_slot_nx, rd_ptr_nx[LW-2:0]}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_prt_nslot.sv
// Directed bench for prt_nslot; read words are checked by a queue-fed monitor.
module tb_prt_nslot;

    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int NS    = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          EN_start_writing_prt_entry;
    logic [1:0]    start_writing_prt_entry;
    logic          RDY_start_writing_prt_entry;
    logic [DW-1:0] write_prt_entry_data;
    logic          EN_write_prt_entry, RDY_write_prt_entry;
    logic          EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry;
    logic          EN_abort_writing_prt_entry, RDY_abort_writing_prt_entry;
    logic [1:0]    invalidate_prt_entry_slot;
    logic          EN_invalidate_prt_entry, RDY_invalidate_prt_entry;
    logic [1:0]    start_reading_prt_entry_slot;
    logic          EN_start_reading_prt_entry, RDY_start_reading_prt_entry;
    logic          EN_read_prt_entry;
    logic [DW:0]   read_prt_entry;
    logic          RDY_read_prt_entry;
    logic          is_prt_slot_free, RDY_is_prt_slot_free;
    logic [NS-1:0] prt_slot_valid;

    int checks   = 0;
    int failures = 0;
    logic [DW:0]   sb [$];
    logic [DW-1:0] exp_words [$];

    prt_nslot #(.DATA_WIDTH(DW), .SLOT_DEPTH(DEPTH), .NUM_SLOTS(NS)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
        .start_writing_prt_entry(start_writing_prt_entry),
        .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
        .write_prt_entry_data(write_prt_entry_data),
        .EN_write_prt_entry(EN_write_prt_entry),
        .RDY_write_prt_entry(RDY_write_prt_entry),
        .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
        .EN_abort_writing_prt_entry(EN_abort_writing_prt_entry),
        .RDY_abort_writing_prt_entry(RDY_abort_writing_prt_entry),
        .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
        .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
        .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
        .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
        .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
        .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
        .EN_read_prt_entry(EN_read_prt_entry),
        .read_prt_entry(read_prt_entry),
        .RDY_read_prt_entry(RDY_read_prt_entry),
        .is_prt_slot_free(is_prt_slot_free),
        .RDY_is_prt_slot_free(RDY_is_prt_slot_free),
        .prt_slot_valid(prt_slot_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every consumed read word is compared against the scoreboard head.
    always @(negedge CLK) begin
        if (RST_N && EN_read_prt_entry) begin
            if (!RDY_read_prt_entry) begin
                chk("read_rdy", 64'(RDY_read_prt_entry), 64'd1);
                if (sb.size() != 0) void'(sb.pop_front());
            end else if (sb.size() == 0) begin
                chk("read_unexpected", 64'(read_prt_entry), 64'h1ff);
            end else begin
                chk("read_word", 64'(read_prt_entry), 64'(sb.pop_front()));
            end
        end
    end

    task automatic start_write(input int exp_slot);
        chk("rdy_start_w", 64'(RDY_start_writing_prt_entry), 64'd1);
        chk("grant", 64'(start_writing_prt_entry), 64'(exp_slot));
        EN_start_writing_prt_entry = 1'b1;
        tick();
        EN_start_writing_prt_entry = 1'b0;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        write_prt_entry_data = d;
        EN_write_prt_entry   = 1'b1;
        tick();
        EN_write_prt_entry   = 1'b0;
    endtask

    task automatic finish();
        EN_finish_writing_prt_entry = 1'b1;
        tick();
        EN_finish_writing_prt_entry = 1'b0;
    endtask

    task automatic inv(input logic [1:0] s);
        invalidate_prt_entry_slot = s;
        EN_invalidate_prt_entry   = 1'b1;
        tick();
        EN_invalidate_prt_entry   = 1'b0;
    endtask

    task automatic start_read(input logic [1:0] s);
        start_reading_prt_entry_slot = s;
        EN_start_reading_prt_entry   = 1'b1;
        tick();
        EN_start_reading_prt_entry   = 1'b0;
    endtask

    task automatic read_all();
        int n;
        n = exp_words.size();
        for (int i = 0; i < n; i++) begin
            sb.push_back({(i == n - 1), exp_words[i]});
            EN_read_prt_entry = 1'b1;
            tick();
        end
        EN_read_prt_entry = 1'b0;
        exp_words.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        EN_start_writing_prt_entry = 0; write_prt_entry_data = '0; EN_write_prt_entry = 0;
        EN_finish_writing_prt_entry = 0; EN_abort_writing_prt_entry = 0;
        invalidate_prt_entry_slot = '0; EN_invalidate_prt_entry = 0;
        start_reading_prt_entry_slot = '0; EN_start_reading_prt_entry = 0; EN_read_prt_entry = 0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        tick();

        chk("rst_rdy_start_w", 64'(RDY_start_writing_prt_entry), 64'd1);
        chk("rst_grant", 64'(start_writing_prt_entry), 64'd0);
        chk("rst_rdy_start_r", 64'(RDY_start_reading_prt_entry), 64'd1);
        chk("rst_free", 64'(is_prt_slot_free), 64'd1);
        chk("rst_rdy_wfa", 64'({RDY_write_prt_entry, RDY_finish_writing_prt_entry,
                                RDY_abort_writing_prt_entry, RDY_read_prt_entry}), 64'd0);
        chk("rst_read", 64'(read_prt_entry), 64'd0);
        chk("rst_valid", 64'(prt_slot_valid), 64'd0);
        chk("rst_const_rdy", 64'({RDY_invalidate_prt_entry, RDY_is_prt_slot_free}), 64'd3);

        // Basic 5-word packet
        start_write(0);
        for (int i = 0; i < 5; i++) write_word(8'(i));
        finish();
        chk("t1_valid", 64'(prt_slot_valid), 64'b0001);
        start_read(0);
        chk("t1_rdy_read", 64'(RDY_read_prt_entry), 64'd1);
        for (int i = 0; i < 5; i++) exp_words.push_back(8'(i));
        read_all();
        chk("t1_read_done", 64'(RDY_read_prt_entry), 64'd0);
        chk("t1_valid_kept", 64'(prt_slot_valid), 64'b0001);

        // Fill remaining slots; slot 3 uses write+finish in one cycle
        start_write(1); write_word(8'h11); finish();
        start_write(2); write_word(8'h12); finish();
        start_write(3);
        write_prt_entry_data = 8'h13;
        EN_write_prt_entry = 1'b1; EN_finish_writing_prt_entry = 1'b1;
        tick();
        EN_write_prt_entry = 1'b0; EN_finish_writing_prt_entry = 1'b0;
        chk("t2_all_valid", 64'(prt_slot_valid), 64'b1111);
        chk("t2_not_free", 64'(is_prt_slot_free), 64'd0);
        chk("t2_no_start", 64'(RDY_start_writing_prt_entry), 64'd0);
        start_read(3);
        exp_words.push_back(8'h13);
        read_all();
        inv(2);
        chk("t2_inv_valid", 64'(prt_slot_valid), 64'b1011);
        chk("t2_inv_free", 64'(is_prt_slot_free), 64'd1);
        start_write(2);
        write_word(8'hA0); write_word(8'hA1); write_word(8'hA2);
        finish();
        start_read(2);
        exp_words.push_back(8'hA0); exp_words.push_back(8'hA1); exp_words.push_back(8'hA2);
        read_all();
        for (int s = 0; s < NS; s++) inv(2'(s));
        chk("t2_cleared", 64'(prt_slot_valid), 64'b0000);

        // Full slot
        start_write(0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("t3_rdy_before_last", 64'(RDY_write_prt_entry), 64'd1);
            write_word(8'(i) ^ 8'h5A);
        end
        chk("t3_full_rdy_w", 64'(RDY_write_prt_entry), 64'd0);
        write_word(8'hFF);
        chk("t3_full_rdy_fin", 64'(RDY_finish_writing_prt_entry), 64'd1);
        finish();
        start_read(0);
        for (int i = 0; i < DEPTH; i++) exp_words.push_back(8'(i) ^ 8'h5A);
        read_all();
        chk("t3_read_done", 64'(RDY_read_prt_entry), 64'd0);
        inv(0);

        // Zero-length entry
        start_write(0);
        finish();
        start_read(0);
        chk("t4_first", 64'(read_prt_entry), 64'h100);
        sb.push_back(9'h100);
        EN_read_prt_entry = 1'b1;
        tick();
        EN_read_prt_entry = 1'b0;
        chk("t4_read_done", 64'(RDY_read_prt_entry), 64'd0);
        inv(0);

        // Abort (finish asserted alongside: abort wins)
        start_write(0);
        write_word(8'h21); write_word(8'h22); write_word(8'h23);
        EN_abort_writing_prt_entry = 1'b1; EN_finish_writing_prt_entry = 1'b1;
        tick();
        EN_abort_writing_prt_entry = 1'b0; EN_finish_writing_prt_entry = 1'b0;
        chk("t5_valid", 64'(prt_slot_valid), 64'b0000);
        chk("t5_rdy_abort", 64'(RDY_abort_writing_prt_entry), 64'd0);
        start_read(0);
        chk("t5_read_ignored", 64'(RDY_read_prt_entry), 64'd0);

        // Concurrent read slot 0 / write slot 1, invalidate slot 0 mid-read
        start_write(0);
        for (int i = 0; i < 4; i++) write_word(8'h30 + 8'(i));
        finish();
        start_read(0);
        chk("t6_rdy_read", 64'(RDY_read_prt_entry), 64'd1);
        start_write(1);
        EN_read_prt_entry = 1'b1; EN_write_prt_entry = 1'b1;
        sb.push_back({1'b0, 8'h30}); write_prt_entry_data = 8'h40;
        tick();
        sb.push_back({1'b0, 8'h31}); write_prt_entry_data = 8'h41;
        tick();
        EN_read_prt_entry = 1'b0;
        invalidate_prt_entry_slot = 2'd0; EN_invalidate_prt_entry = 1'b1;
        write_prt_entry_data = 8'h42;
        tick();
        EN_invalidate_prt_entry = 1'b0;
        chk("t6_read_dropped", 64'(RDY_read_prt_entry), 64'd0);
        write_prt_entry_data = 8'h43;
        tick();
        EN_write_prt_entry = 1'b0;
        finish();
        chk("t6_valid", 64'(prt_slot_valid), 64'b0010);
        start_read(1);
        for (int i = 0; i < 4; i++) exp_words.push_back(8'h40 + 8'(i));
        read_all();

        // Reset mid-operation
        start_write(0);
        write_word(8'h55);
        RST_N = 1'b0;
        #3 RST_N = 1'b1;
        tick();
        chk("t7_rst_valid", 64'(prt_slot_valid), 64'b0000);
        chk("t7_rst_rdy_w", 64'(RDY_write_prt_entry), 64'd0);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
